alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator/sequencer for the datapath ALU. Accepts operation requests on a valid/ready interface and drives the ALU's operand, control and carry-in inputs from registers.
- Waits the op-dependent latency, then captures the ALU result and flags into a registered response held until the consumer accepts it.
- Sits between the decode/issue logic and the ALU. Absorbs the clocked latency of the shift-then-compare pattern matcher.

Parameters:
- DATA_WIDTH, 64, operand/result width; must match the ALU.
- TAG_WIDTH, 4, opaque request tag returned with the response.
- STC_LATENCY, 2, cycles operands are held before sampling a shift-then-compare result; must be >= 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_op_i  in  4  ALU control code.
- req_a_i  in  DATA_WIDTH  operand 1.
- req_b_i  in  DATA_WIDTH  operand 2 (shift amount for shifts, pattern for shift-then-compare).
- req_cin_i  in  1  carry-in.
- req_tag_i  in  TAG_WIDTH  request tag.
- alu_in1_o  out  DATA_WIDTH  registered operand 1 to the ALU.
- alu_in2_o  out  DATA_WIDTH  registered operand 2 to the ALU.
- aluctrl_o  out  4  registered control code to the ALU.
- cin_o  out  1  registered carry-in to the ALU.
- alu_res_i  in  DATA_WIDTH  ALU result.
- alu_cout_i  in  1  ALU carry-out.
- alu_gt_i  in  1  ALU a>b flag.
- alu_lt_i  in  1  ALU a<b flag.
- alu_eq_i  in  1  ALU equal/zero flag.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts the response.
- rsp_data_o  out  DATA_WIDTH  captured result.
- rsp_cout_o  out  1  captured carry-out.
- rsp_gt_o  out  1  captured a>b flag.
- rsp_lt_o  out  1  captured a<b flag.
- rsp_eq_o  out  1  captured equal flag.
- rsp_illegal_o  out  1  request op code was illegal.
- rsp_tag_o  out  TAG_WIDTH  tag of the request being answered.

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE, counter 0.
  - Every output register is 0: alu_in1_o, alu_in2_o, aluctrl_o, cin_o, all rsp_* outputs, including rsp_valid_o.
  - Any in-flight operation is dropped with no response. req_ready_o is 1 once reset is released.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_o = 1; in EXEC and RESP req_ready_o = 0.
  - On req_valid_i && req_ready_o, register op, a, b, cin, tag, load cnt = 0, go to EXEC.
  - Legal codes: 0000, 0001, 0010, 0101, 0110, 0111, 1000, 1001.
  - Any other code (0011, 0100, 1010-1111) skips EXEC and goes directly to RESP. The response is data 0, all flags 0, rsp_illegal_o = 1. The ALU inputs are not updated.
- EXEC:
  - ALU inputs stay stable from the registered request throughout.
  - Latency L = STC_LATENCY for 1001, L = 1 for all other legal codes.
  - cnt increments each cycle. When cnt == L-1, capture alu_res_i into rsp_data_o and go to RESP.
- Flag capture (illegal = 0 for every legal code):
  - 0010: capture cout; gt/lt/eq are 0.
  - 0110 (SUB and COMPARE share this code): capture data, cout, gt, lt and eq.
  - All other codes: cout, gt, lt and eq are 0.
  - 1001: data is the zero-extended match bit.
- RESP:
  - rsp_valid_o = 1; all rsp_* outputs stay stable while rsp_valid_o && !rsp_ready_i.
  - On rsp_ready_i, rsp_valid_o drops the next cycle and the state returns to IDLE.
  - No new request is accepted in the handshake cycle; minimum issue interval is L + 2 cycles.
- Timing, legal op with L = 1, accepted at edge N:
  - ALU inputs valid after edge N.
  - Result sampled at edge N+1; rsp_valid_o is high from the cycle after edge N+1.
- ALU input registers hold their last value after the response. They change only on a legal accept.
- Shift amounts are passed to the ALU unmodified; a value >= DATA_WIDTH gives whatever the ALU produces, with no saturation here.
- Counter width is $clog2(STC_LATENCY+1).

Decomposition:
- Shared package alu_pkg holds:
  - The ALU op-code constants: ADD 0010, SUB/COMPARE 0110, AND 0000, OR 0001, XNOR 0101, LSL 0111, LSR 1000, STC 1001, SUBSTR 1010.
  - An is_legal_op function and a latency-select function.
  - The IDLE/EXEC/RESP state encoding.
- No sub-module is required. A single FSM plus registers is sufficient.

Test Plan:
- ADD, a=5, b=7, cin=0, tag=3 -> rsp_data=12, cout=0, flags 0, illegal=0, tag=3; rsp_valid_o high 2 cycles after accept.
- Op 0110, a=3, b=9 -> rsp_lt=1, gt=0, eq=0, data = ALU difference, cout = ALU cout. Repeat with a=b=0x55 -> eq=1.
- STC (1001) with STC_LATENCY=2, ALU model asserting the match after 2 cycles -> rsp_data=1, rsp_valid_o 3 cycles after accept, ALU inputs stable throughout.
- Op 1011 -> rsp_illegal=1, data=0, alu_in1_o/alu_in2_o/aluctrl_o unchanged from the previous op.
- Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_* stable, req_ready_o=0. Release -> rsp_valid_o drops next cycle, req_ready_o=1.
- Assert reset low during EXEC -> all outputs 0 immediately (asynchronous). After release, no stale response appears and a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller:
// op codes, op classification and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_XNOR   = 4'b0101;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_LSL    = 4'b0111;
    localparam logic [3:0] OP_LSR    = 4'b1000;
    localparam logic [3:0] OP_STC    = 4'b1001;
    localparam logic [3:0] OP_SUBSTR = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_XNOR,
            OP_SUB, OP_LSL, OP_LSR, OP_STC: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Cycles the operands must be held before the result is sampled.
    function automatic int unsigned op_latency(
        input logic [3:0]  op,
        input int unsigned stc_lat
    );
        return (op == OP_STC) ? stc_lat : 1;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Request sequencer for the datapath ALU: registers operands,
// waits the op latency, then holds the captured response.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned STC_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3:0]            req_op_i,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    input  logic                  req_cin_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output logic [DATA_WIDTH-1:0] alu_in1_o,
    output logic [DATA_WIDTH-1:0] alu_in2_o,
    output logic [3:0]            aluctrl_o,
    output logic                  cin_o,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    input  logic                  alu_cout_i,
    input  logic                  alu_gt_i,
    input  logic                  alu_lt_i,
    input  logic                  alu_eq_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_cout_o,
    output logic                  rsp_gt_o,
    output logic                  rsp_lt_o,
    output logic                  rsp_eq_o,
    output logic                  rsp_illegal_o,
    output logic [TAG_WIDTH-1:0]  rsp_tag_o
);

    localparam int CW = $clog2(STC_LATENCY + 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        last_cnt;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 is_add;
    logic                 is_sub;

    // aluctrl_o doubles as the registered op of the request in flight.
    assign last_cnt = CW'(op_latency(aluctrl_o, STC_LATENCY) - 1);
    assign is_add   = (aluctrl_o == OP_ADD);
    assign is_sub   = (aluctrl_o == OP_SUB);

    assign req_ready_o = reset && (state == ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            tag_q         <= '0;
            alu_in1_o     <= '0;
            alu_in2_o     <= '0;
            aluctrl_o     <= '0;
            cin_o         <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_cout_o    <= 1'b0;
            rsp_gt_o      <= 1'b0;
            rsp_lt_o      <= 1'b0;
            rsp_eq_o      <= 1'b0;
            rsp_illegal_o <= 1'b0;
            rsp_tag_o     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        tag_q <= req_tag_i;
                        if (is_legal_op(req_op_i)) begin
                            alu_in1_o <= req_a_i;
                            alu_in2_o <= req_b_i;
                            aluctrl_o <= req_op_i;
                            cin_o     <= req_cin_i;
                            cnt       <= '0;
                            state     <= ST_EXEC;
                        end else begin
                            // Illegal ops never reach the ALU.
                            rsp_valid_o   <= 1'b1;
                            rsp_data_o    <= '0;
                            rsp_cout_o    <= 1'b0;
                            rsp_gt_o      <= 1'b0;
                            rsp_lt_o      <= 1'b0;
                            rsp_eq_o      <= 1'b0;
                            rsp_illegal_o <= 1'b1;
                            rsp_tag_o     <= req_tag_i;
                            state         <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == last_cnt) begin
                        rsp_valid_o   <= 1'b1;
                        rsp_data_o    <= (aluctrl_o == OP_STC)
                                       ? {{(DATA_WIDTH-1){1'b0}}, alu_res_i[0]}
                                       : alu_res_i;
                        rsp_cout_o    <= (is_add || is_sub) && alu_cout_i;
                        rsp_gt_o      <= is_sub && alu_gt_i;
                        rsp_lt_o      <= is_sub && alu_lt_i;
                        rsp_eq_o      <= is_sub && alu_eq_i;
                        rsp_illegal_o <= 1'b0;
                        rsp_tag_o     <= tag_q;
                        state         <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU
// whose STC result only settles after the operands are held.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DW = 64;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          req_cin;
    logic [TW-1:0] req_tag;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [3:0]    aluctrl;
    logic          cin;
    logic [DW-1:0] m_res;
    logic          m_cout;
    logic          m_gt;
    logic          m_lt;
    logic          m_eq;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_cout;
    logic          rsp_gt;
    logic          rsp_lt;
    logic          rsp_eq;
    logic          rsp_illegal;
    logic [TW-1:0] rsp_tag;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .STC_LATENCY(2)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_cin_i    (req_cin),
        .req_tag_i    (req_tag),
        .alu_in1_o    (alu_in1),
        .alu_in2_o    (alu_in2),
        .aluctrl_o    (aluctrl),
        .cin_o        (cin),
        .alu_res_i    (m_res),
        .alu_cout_i   (m_cout),
        .alu_gt_i     (m_gt),
        .alu_lt_i     (m_lt),
        .alu_eq_i     (m_eq),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_cout_o   (rsp_cout),
        .rsp_gt_o     (rsp_gt),
        .rsp_lt_o     (rsp_lt),
        .rsp_eq_o     (rsp_eq),
        .rsp_illegal_o(rsp_illegal),
        .rsp_tag_o    (rsp_tag)
    );

    // STC match is valid only once inputs were stable over one edge.
    logic [DW*2+3:0] prev_in = '0;
    int              age = 0;
    int              age_eff;
    logic            stc_m;

    assign age_eff = ({alu_in1, alu_in2, aluctrl} == prev_in) ? age : 0;
    assign stc_m   = (age_eff >= 1) && (alu_in1 == alu_in2);

    always @(posedge clk) begin
        prev_in <= {alu_in1, alu_in2, aluctrl};
        age     <= (age_eff >= 15) ? 15 : age_eff + 1;
    end

    always_comb begin
        m_res  = '0;
        m_cout = 1'b0;
        case (aluctrl)
            OP_ADD:  {m_cout, m_res} = {1'b0, alu_in1} + {1'b0, alu_in2}
                                     + {{DW{1'b0}}, cin};
            OP_SUB:  {m_cout, m_res} = {1'b0, alu_in1} + {1'b0, ~alu_in2}
                                     + {{DW{1'b0}}, 1'b1};
            OP_AND:  m_res = alu_in1 & alu_in2;
            OP_OR:   m_res = alu_in1 | alu_in2;
            OP_XNOR: m_res = ~(alu_in1 ^ alu_in2);
            OP_LSL:  m_res = alu_in1 << alu_in2[5:0];
            OP_LSR:  m_res = alu_in1 >> alu_in2[5:0];
            OP_STC:  m_res = {alu_in1[DW-1:1], stc_m};
            default: m_res = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
        m_gt = alu_in1 > alu_in2;
        m_lt = alu_in1 < alu_in2;
        m_eq = alu_in1 == alu_in2;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic c,
                         input logic [TW-1:0] t);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = c;
        req_tag   = t;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("hs_valid_drop", rsp_valid, 0);
        chk("hs_ready_back", req_ready, 1);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_in1", alu_in1, 0);
        chk("rst_ctrl", aluctrl, 0);
        chk("rst_data", rsp_data, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);

        // ADD 5+7
        issue(OP_ADD, 5, 7, 1'b0, 4'd3);
        chk("add_in1", alu_in1, 5);
        chk("add_in2", alu_in2, 7);
        chk("add_ctrl", aluctrl, OP_ADD);
        chk("add_busy", req_ready, 0);
        chk("add_early", rsp_valid, 0);
        wait_rsp(lat);
        chk("add_lat", lat, 1);
        chk("add_data", rsp_data, 12);
        chk("add_cout", rsp_cout, 0);
        chk("add_lt", rsp_lt, 0);
        chk("add_ill", rsp_illegal, 0);
        chk("add_tag", rsp_tag, 3);
        handshake();

        // SUB/COMPARE 3 vs 9
        issue(OP_SUB, 3, 9, 1'b0, 4'd5);
        wait_rsp(lat);
        chk("sub_lat", lat, 1);
        chk("sub_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("sub_cout", rsp_cout, 0);
        chk("sub_lt", rsp_lt, 1);
        chk("sub_gt", rsp_gt, 0);
        chk("sub_eq", rsp_eq, 0);
        chk("sub_tag", rsp_tag, 5);
        handshake();

        // COMPARE equal
        issue(OP_SUB, 64'h55, 64'h55, 1'b0, 4'd6);
        wait_rsp(lat);
        chk("eq_data", rsp_data, 0);
        chk("eq_cout", rsp_cout, 1);
        chk("eq_eq", rsp_eq, 1);
        chk("eq_lt", rsp_lt, 0);
        handshake();

        // STC, two-cycle latency
        issue(OP_STC, 64'hAB, 64'hAB, 1'b0, 4'd7);
        chk("stc_in1_0", alu_in1, 64'hAB);
        @(posedge clk);
        #1;
        chk("stc_early", rsp_valid, 0);
        chk("stc_in1_1", alu_in1, 64'hAB);
        chk("stc_in2_1", alu_in2, 64'hAB);
        chk("stc_ctrl_1", aluctrl, OP_STC);
        @(posedge clk);
        #1;
        chk("stc_valid", rsp_valid, 1);
        chk("stc_data", rsp_data, 1);
        chk("stc_tag", rsp_tag, 7);
        handshake();

        // Illegal op leaves ALU inputs alone
        issue(4'b1011, 64'h1111, 64'h2222, 1'b1, 4'd8);
        chk("ill_valid", rsp_valid, 1);
        chk("ill_flag", rsp_illegal, 1);
        chk("ill_data", rsp_data, 0);
        chk("ill_tag", rsp_tag, 8);
        chk("ill_in1", alu_in1, 64'hAB);
        chk("ill_in2", alu_in2, 64'hAB);
        chk("ill_ctrl", aluctrl, OP_STC);
        chk("ill_cin", cin, 0);
        handshake();

        // Backpressure
        issue(OP_ADD, 100, 200, 1'b1, 4'd9);
        wait_rsp(lat);
        chk("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 301);
            chk("bp_tag", rsp_tag, 9);
            chk("bp_ready", req_ready, 0);
        end
        handshake();

        // Asynchronous reset in the middle of EXEC
        issue(OP_STC, 64'h12, 64'h34, 1'b1, 4'd2);
        chk("ar_in1", alu_in1, 64'h12);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_in1_0", alu_in1, 0);
        chk("ar_in2_0", alu_in2, 0);
        chk("ar_ctrl_0", aluctrl, 0);
        chk("ar_cin_0", cin, 0);
        chk("ar_valid_0", rsp_valid, 0);
        chk("ar_tag_0", rsp_tag, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("ar_no_stale", rsp_valid, 0);
        end
        chk("ar_ready", req_ready, 1);
        issue(OP_ADD, 1, 1, 1'b1, 4'hA);
        wait_rsp(lat);
        chk("ar_add_lat", lat, 1);
        chk("ar_add_data", rsp_data, 3);
        chk("ar_add_tag", rsp_tag, 4'hA);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
